// File: rtl/hex_led_avmm_slave.sv
// hex_led_avmm_slave: Avalon-MM peripheral driving LEDR/HEX0-5
// and sampling SW/KEY with key-press flags and interrupt.
module hex_led_avmm_slave #(
  parameter int BLINK_W     = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic [3:0]  avs_byteenable,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        irq,
  input  logic [9:0]  sw_i,
  input  logic [3:0]  key_i,
  output logic [9:0]  ledr_o,
  output logic [6:0]  hex0_o,
  output logic [6:0]  hex1_o,
  output logic [6:0]  hex2_o,
  output logic [6:0]  hex3_o,
  output logic [6:0]  hex4_o,
  output logic [6:0]  hex5_o
);

  logic [9:0]  ledr_q, ledr_d;
  logic [23:0] data_q, data_d;
  logic [17:0] ctrl_q, ctrl_d;
  logic [31:0] raw0_q, raw0_d;
  logic [15:0] raw1_q, raw1_d;
  logic [BLINK_W-1:0] per_q, per_d;
  logic [BLINK_W-1:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic [3:0]  evt_q, evt_d;
  logic [3:0]  mask_q, mask_d;
  logic        irq_q, irq_d;
  logic [SYNC_STAGES-1:0][9:0] sw_s_q, sw_s_d;
  logic [SYNC_STAGES-1:0][3:0] key_s_q, key_s_d;
  logic [3:0]  key_prev_q, key_prev_d;
  logic [5:0][6:0] hex_q, hex_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;

  logic [9:0]  sw_s;
  logic [3:0]  key_s, press, clr;
  logic [31:0] rmux, wmrg, bmask;
  logic [5:0][6:0] raw_all;
  logic        blink_wr;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    unique case (n)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      4'hF: seg7 = 7'h0E;
    endcase
  endfunction

  assign sw_s  = sw_s_q[SYNC_STAGES-1];
  assign key_s = key_s_q[SYNC_STAGES-1];
  assign press = key_prev_q & ~key_s;

  always_comb begin
    rmux = '0;
    unique case (avs_address)
      3'd0: rmux = {22'b0, ledr_q};
      3'd1: rmux = {8'b0, data_q};
      3'd2: rmux = {14'b0, ctrl_q};
      3'd3: rmux = raw0_q;
      3'd4: rmux = {16'b0, raw1_q};
      3'd5: rmux = 32'(per_q);
      3'd6: rmux = {18'b0, key_s, sw_s};
      3'd7: rmux = {20'b0, mask_q, 4'b0, evt_q};
    endcase
  end

  // Merge against the current readback so unused bits stay zero
  always_comb begin
    for (int i = 0; i < 4; i++)
      bmask[8*i +: 8] = {8{avs_byteenable[i]}};
    wmrg = (rmux & ~bmask) | (avs_writedata & bmask);
  end

  always_comb begin
    ledr_d = ledr_q;
    data_d = data_q;
    ctrl_d = ctrl_q;
    raw0_d = raw0_q;
    raw1_d = raw1_q;
    per_d  = per_q;
    mask_d = mask_q;
    clr    = '0;
    if (avs_write) begin
      case (avs_address)
        3'd0: ledr_d = wmrg[9:0];
        3'd1: data_d = wmrg[23:0];
        3'd2: ctrl_d = wmrg[17:0];
        3'd3: raw0_d = wmrg & 32'h7F7F7F7F;
        3'd4: raw1_d = wmrg[15:0] & 16'h7F7F;
        3'd5: per_d  = wmrg[BLINK_W-1:0];
        3'd7: begin
          mask_d = wmrg[11:8];
          clr    = avs_writedata[3:0]
                 & {4{avs_byteenable[0]}};
        end
        default: ;
      endcase
    end
    evt_d      = (evt_q & ~clr) | press;
    irq_d      = |(evt_q & mask_q);
    key_prev_d = key_s;
    sw_s_d     = {sw_s_q[SYNC_STAGES-2:0], sw_i};
    key_s_d    = {key_s_q[SYNC_STAGES-2:0], key_i};
    rvalid_d   = avs_read;
    rdata_d    = avs_read ? rmux : '0;
  end

  assign blink_wr = avs_write && (avs_address == 3'd5);

  always_comb begin
    cnt_d   = cnt_q + BLINK_W'(1);
    phase_d = phase_q;
    if (blink_wr || per_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q >= per_q - BLINK_W'(1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  assign raw_all = {raw1_q[14:8], raw1_q[6:0],
                    raw0_q[30:24], raw0_q[22:16],
                    raw0_q[14:8], raw0_q[6:0]};

  always_comb begin
    for (int n = 0; n < 6; n++) begin
      if (!ctrl_q[n])
        hex_d[n] = 7'h7F;
      else if (ctrl_q[6+n])
        hex_d[n] = raw_all[n];
      else
        hex_d[n] = seg7(data_q[4*n +: 4]);
      if (ctrl_q[12+n] && !phase_q)
        hex_d[n] = 7'h7F;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ledr_q     <= '0;
      data_q     <= '0;
      ctrl_q     <= '0;
      raw0_q     <= 32'h7F7F7F7F;
      raw1_q     <= 16'h7F7F;
      per_q      <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b1;
      evt_q      <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
      sw_s_q     <= '0;
      key_s_q    <= '1;
      key_prev_q <= '1;
      hex_q      <= {6{7'h7F}};
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      ledr_q     <= ledr_d;
      data_q     <= data_d;
      ctrl_q     <= ctrl_d;
      raw0_q     <= raw0_d;
      raw1_q     <= raw1_d;
      per_q      <= per_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      evt_q      <= evt_d;
      mask_q     <= mask_d;
      irq_q      <= irq_d;
      sw_s_q     <= sw_s_d;
      key_s_q    <= key_s_d;
      key_prev_q <= key_prev_d;
      hex_q      <= hex_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign ledr_o            = ledr_q;
  assign irq               = irq_q;
  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign hex0_o            = hex_q[0];
  assign hex1_o            = hex_q[1];
  assign hex2_o            = hex_q[2];
  assign hex3_o            = hex_q[3];
  assign hex4_o            = hex_q[4];
  assign hex5_o            = hex_q[5];

endmodule

// File: tb/tb_hex_led_avmm_slave.sv
// tb_hex_led_avmm_slave: directed bench for the
// LED/HEX/SW/KEY Avalon-MM peripheral.
module tb_hex_led_avmm_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [3:0]  avs_byteenable = '0;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        irq;
  logic [9:0]  sw_i = '0;
  logic [3:0]  key_i = 4'hF;
  logic [9:0]  ledr_o;
  wire  [6:0]  hv [6];

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  hex_led_avmm_slave #(.BLINK_W(24), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .irq(irq), .sw_i(sw_i), .key_i(key_i), .ledr_o(ledr_o),
    .hex0_o(hv[0]), .hex1_o(hv[1]), .hex2_o(hv[2]),
    .hex3_o(hv[3]), .hex4_o(hv[4]), .hex5_o(hv[5])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    avs_address = a;
    avs_writedata = d;
    avs_byteenable = be;
    avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d,
                    output logic v);
    avs_address = a;
    avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    d = avs_readdata;
    v = avs_readdatavalid;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v;
    #12;
    vecs++;
    if (ledr_o !== 10'h0) begin
      errs++; $display("FAIL rst_ledr got %h want 000", ledr_o);
    end
    for (int n = 0; n < 6; n++) begin
      vecs++;
      if (hv[n] !== 7'h7F) begin
        errs++; $display("FAIL rst_hex%0d got %h want 7f", n, hv[n]);
      end
    end
    vecs++;
    if (avs_readdatavalid !== 1'b0 || irq !== 1'b0
        || avs_readdata !== 32'h0) begin
      errs++;
      $display("FAIL rst_bus got rv=%b irq=%b rd=%h want 0 0 0",
               avs_readdatavalid, irq, avs_readdata);
    end
    rst_n = 1'b1;
    tick();
    wr(3'd0, 32'h0000_02A5, 4'hF);
    vecs++;
    if (ledr_o !== 10'h2A5) begin
      errs++; $display("FAIL ledr_wr got %h want 2a5", ledr_o);
    end
    wr(3'd2, 32'h0000_003F, 4'hF);
    tick();
    vecs++;
    if (hv[0] !== 7'h40) begin
      errs++; $display("FAIL pre_rst_hex0 got %h want 40", hv[0]);
    end
    avs_address = 3'd0;
    avs_read = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    vecs++;
    if (ledr_o !== 10'h0 || hv[0] !== 7'h7F) begin
      errs++;
      $display("FAIL async_rst got ledr=%h hex0=%h want 000 7f",
               ledr_o, hv[0]);
    end
    @(posedge clk);
    #1;
    vecs++;
    if (avs_readdatavalid !== 1'b0 || irq !== 1'b0) begin
      errs++;
      $display("FAIL rst_read got rv=%b irq=%b want 0 0",
               avs_readdatavalid, irq);
    end
    avs_read = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    rd(3'd3, d, v);
    vecs++;
    if (d !== 32'h7F7F7F7F || v !== 1'b1) begin
      errs++;
      $display("FAIL raw0_rst got %h v=%b want 7f7f7f7f v=1", d, v);
    end
    tick();
    vecs++;
    if (avs_readdatavalid !== 1'b0) begin
      errs++; $display("FAIL rv_one got 1 want 0");
    end
  endtask

  task automatic test_decode();
    logic [31:0] pat [3];
    logic [6:0]  exp [3][6];
    logic [31:0] d;
    logic v;
    pat[0] = 32'h0012_3456;
    exp[0] = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    pat[1] = 32'h00AB_CDEF;
    exp[1] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08};
    pat[2] = 32'h0098_7000;
    exp[2] = '{7'h40, 7'h40, 7'h40, 7'h78, 7'h00, 7'h10};
    wr(3'd1, pat[0], 4'hF);
    wr(3'd2, 32'h0000_003F, 4'hF);
    vecs++;
    if (hv[0] !== 7'h7F) begin
      errs++; $display("FAIL hex_lat got %h want 7f", hv[0]);
    end
    for (int p = 0; p < 3; p++) begin
      if (p != 0) wr(3'd1, pat[p], 4'hF);
      tick();
      for (int n = 0; n < 6; n++) begin
        vecs++;
        if (hv[n] !== exp[p][n]) begin
          errs++;
          $display("FAIL dec%0d_hex%0d got %h want %h",
                   p, n, hv[n], exp[p][n]);
        end
      end
    end
    wr(3'd1, pat[0], 4'hF);
    rd(3'd1, d, v);
    vecs++;
    if (d !== 32'h0012_3456 || v !== 1'b1) begin
      errs++; $display("FAIL rd_data got %h v=%b want 00123456", d, v);
    end
  endtask

  task automatic test_raw();
    logic [31:0] d;
    logic v;
    wr(3'd2, 32'h0000_0041, 4'hF);
    wr(3'd3, 32'h0000_007F, 4'hF);
    tick();
    vecs++;
    if (hv[0] !== 7'h7F) begin
      errs++; $display("FAIL raw_7f got %h want 7f", hv[0]);
    end
    wr(3'd3, 32'h0000_0009, 4'hF);
    tick();
    vecs++;
    if (hv[0] !== 7'h09 || hv[1] !== 7'h7F) begin
      errs++;
      $display("FAIL raw_09 got %h %h want 09 7f", hv[0], hv[1]);
    end
    wr(3'd3, 32'h0000_5A00, 4'b0010);
    tick();
    vecs++;
    if (hv[0] !== 7'h09) begin
      errs++; $display("FAIL be_hex0 got %h want 09", hv[0]);
    end
    rd(3'd3, d, v);
    vecs++;
    if (d !== 32'h0000_5A09) begin
      errs++; $display("FAIL be_raw0 got %h want 00005a09", d);
    end
    wr(3'd3, 32'hFFFF_FFFF, 4'hF);
    rd(3'd3, d, v);
    vecs++;
    if (d !== 32'h7F7F7F7F) begin
      errs++; $display("FAIL raw0_unused got %h want 7f7f7f7f", d);
    end
    wr(3'd0, 32'h0000_0312, 4'b0010);
    rd(3'd0, d, v);
    vecs++;
    if (d !== 32'h0000_0300) begin
      errs++; $display("FAIL be_ledr got %h want 00000300", d);
    end
  endtask

  task automatic test_inputs();
    logic [31:0] d;
    logic v;
    sw_i = 10'h155;
    repeat (3) tick();
    rd(3'd6, d, v);
    vecs++;
    if (d !== 32'h0000_3D55) begin
      errs++; $display("FAIL inputs got %h want 00003d55", d);
    end
    wr(3'd6, 32'h0000_0000, 4'hF);
    rd(3'd6, d, v);
    vecs++;
    if (d !== 32'h0000_3D55) begin
      errs++; $display("FAIL inputs_ro got %h want 00003d55", d);
    end
  endtask

  task automatic test_blink();
    logic [6:0] e;
    wr(3'd1, 32'h0000_0005, 4'hF);
    wr(3'd2, 32'h0000_1001, 4'hF);
    wr(3'd5, 32'h0000_0004, 4'hF);
    for (int k = 1; k <= 12; k++) begin
      tick();
      e = (((k - 1) / 4) % 2 == 0) ? 7'h12 : 7'h7F;
      vecs++;
      if (hv[0] !== e) begin
        errs++;
        $display("FAIL blink_k%0d got %h want %h", k, hv[0], e);
      end
    end
    repeat (2) tick();
    wr(3'd5, 32'h0000_0000, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      tick();
      vecs++;
      if (hv[0] !== 7'h12) begin
        errs++;
        $display("FAIL blink_off_k%0d got %h want 12", k, hv[0]);
      end
    end
  endtask

  task automatic test_key();
    logic [31:0] d;
    logic v;
    wr(3'd7, 32'h0000_0400, 4'b0010);
    key_i = 4'hB;
    tick();
    tick();
    vecs++;
    if (irq !== 1'b0) begin
      errs++; $display("FAIL irq_early got 1 want 0");
    end
    avs_address = 3'd7;
    avs_read = 1'b1;
    tick();
    vecs++;
    if (avs_readdata !== 32'h400 || avs_readdatavalid !== 1'b1
        || irq !== 1'b0) begin
      errs++;
      $display("FAIL evt_e3 got %h v=%b irq=%b want 400 1 0",
               avs_readdata, avs_readdatavalid, irq);
    end
    tick();
    avs_read = 1'b0;
    vecs++;
    if (avs_readdata !== 32'h404 || avs_readdatavalid !== 1'b1
        || irq !== 1'b1) begin
      errs++;
      $display("FAIL evt_e4 got %h v=%b irq=%b want 404 1 1",
               avs_readdata, avs_readdatavalid, irq);
    end
    key_i = 4'hF;
    repeat (4) tick();
    key_i = 4'hB;
    tick();
    tick();
    wr(3'd7, 32'h0000_0004, 4'b0001);
    rd(3'd7, d, v);
    vecs++;
    if (d !== 32'h404 || irq !== 1'b1) begin
      errs++;
      $display("FAIL set_wins got %h irq=%b want 404 1", d, irq);
    end
    key_i = 4'hF;
    repeat (4) tick();
    wr(3'd7, 32'h0000_0004, 4'b0001);
    tick();
    vecs++;
    if (irq !== 1'b0) begin
      errs++; $display("FAIL w1c_irq got 1 want 0");
    end
    rd(3'd7, d, v);
    vecs++;
    if (d !== 32'h400) begin
      errs++; $display("FAIL w1c_evt got %h want 400", d);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_raw();
    test_inputs();
    test_blink();
    test_key();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
